// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and default bit period.
// Used by both the receive deframer and the transmitter.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 5208;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Write-side FIFO port of the UART receiver: byte, strobes and status.
// The deframer uses the master modport; the downstream FIFO uses the slave.
interface uart_rx_deframer_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] rx_data;
    logic                   rx_valid;
    logic                   frame_err;
    logic                   overrun;
    logic                   busy;
    logic                   rx_full;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy,
        input  rx_full
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy,
        output rx_full
    );

endinterface

// File: rtl/uart_rxd_sync.sv
// Two-flop synchroniser for the serial line plus a delayed copy for edge detection.
// rxd_valid rises once the chain holds real line samples rather than reset ones.
module uart_rxd_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd_async,
    output logic rxd_s,
    output logic rxd_d,
    output logic rxd_valid
);

    logic       meta_q, meta_d;
    logic       sync_q, sync_d;
    logic       dly_q,  dly_d;
    logic [1:0] fill_q, fill_d;

    always_comb begin
        meta_d = rxd_async;
        sync_d = meta_q;
        dly_d  = sync_q;
        fill_d = {fill_q[0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            dly_q  <= 1'b1;
            fill_q <= 2'b00;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
            fill_q <= fill_d;
        end
    end

    assign rxd_s     = sync_q;
    assign rxd_d     = dly_q;
    assign rxd_valid = fill_q[1];

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start-bit validation, mid-bit sampling, stop check, FIFO strobe.
// Define UART_RX_PARITY_EN for 8-bit + parity frames; default build is 8N1.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               uart_rxd,
    uart_rx_deframer_if.master fifo
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic rxd_s, rxd_d, rxd_valid;

    uart_rxd_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd_async (uart_rxd),
        .rxd_s     (rxd_s),
        .rxd_d     (rxd_d),
        .rxd_valid (rxd_valid)
    );

    uart_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   armed_q, armed_d;
    logic [UART_DATA_W-1:0] rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;
    logic                   par_ok;

`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    assign par_ok = ((^shift_q) ^ par_q) == PARITY_ODD;
`else
    logic                   unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
    assign par_ok            = 1'b1;
`endif

    // Start detection needs a genuine high line first, so a line stuck low out of reset is ignored.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        armed_d     = armed_q | (rxd_valid & rxd_s);
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (armed_q && rxd_d && !rxd_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[UART_DATA_W-1:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rxd_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            // Leave mid stop bit so a back-to-back start edge is still seen.
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!rxd_s || !par_ok) begin
                        frame_err_d = 1'b1;
                    end else if (fifo.rx_full) begin
                        overrun_d = 1'b1;
                    end else begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= '0;
            armed_q     <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign fifo.rx_data   = rx_data_q;
    assign fifo.rx_valid  = rx_valid_q;
    assign fifo.frame_err = frame_err_q;
    assign fifo.overrun   = overrun_q;
    assign fifo.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at 16 clocks per bit: frame table plus corner sequences.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx_deframer;

    localparam int CPB      = 16;
    localparam bit PAR_ODD  = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_CYC = 11 * CPB;
    localparam int LAT       = 3 + CPB / 2 + 10 * CPB + 1;
`else
    localparam int FRAME_CYC = 10 * CPB;
    localparam int LAT       = 3 + CPB / 2 + 9 * CPB + 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic uart_rxd;

    uart_rx_deframer_if rx_if ();

    uart_rx_deframer #(
        .CLKS_PER_BIT (CPB),
        .PARITY_ODD   (PAR_ODD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rxd (uart_rxd),
        .fifo     (rx_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int both_cnt = 0;
    int wide_cnt = 0;
    int busy_rise_cnt = 0;
    int busy_rise_cyc = 0;
    int last_drive_cyc = 0;
    logic prev_valid = 1'b0;
    logic prev_busy = 1'b0;
    int valid_cyc_q[$];
    logic [7:0] valid_dat_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge, away from the DUT update edge.
    always @(negedge clk) begin
        if (rx_if.rx_valid) begin
            valid_cnt++;
            valid_cyc_q.push_back(cyc);
            valid_dat_q.push_back(rx_if.rx_data);
            if (prev_valid) wide_cnt++;
        end
        prev_valid = rx_if.rx_valid;
        if (rx_if.frame_err) ferr_cnt++;
        if (rx_if.overrun) ovr_cnt++;
        if (rx_if.frame_err && rx_if.overrun) both_cnt++;
        if (rx_if.busy && !prev_busy) begin
            busy_rise_cnt++;
            busy_rise_cyc = cyc;
        end
        prev_busy = rx_if.busy;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       full;
        int         exp_valid;
        int         exp_ferr;
        int         exp_ovr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(posedge clk);
        #1;
        uart_rxd = b;
        last_drive_cyc = cyc;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par,
                              output int start_cyc);
        drive_bit(1'b0);
        start_cyc = last_drive_cyc;
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ PAR_ODD ^ bad_par);
`else
        if (bad_par) $display("[TB] note: parity not compiled in");
`endif
        drive_bit(stop_bit);
    endtask

    task automatic line_idle(input int cycles);
        @(posedge clk);
        #1;
        uart_rxd = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int v0, f0, o0, sc;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        rx_if.rx_full = v.full;
        send_frame(v.data, v.stop_bit, 1'b0, sc);
        line_idle(2 * CPB);
        rx_if.rx_full = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("vec%0d_valid", idx), valid_cnt - v0, v.exp_valid);
        checkOutput($sformatf("vec%0d_ferr", idx), ferr_cnt - f0, v.exp_ferr);
        checkOutput($sformatf("vec%0d_ovr", idx), ovr_cnt - o0, v.exp_ovr);
        checkOutput($sformatf("vec%0d_data", idx), int'(rx_if.rx_data), int'(v.exp_data));
    endtask

    initial begin
        int sc, n0, v0, f0, b0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 0, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 0, 1, 0, 8'hA5};
        vecs[2] = '{8'h5A, 1'b1, 1'b1, 0, 0, 1, 8'hA5};
        vecs[3] = '{8'h11, 1'b1, 1'b0, 1, 0, 0, 8'h11};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 1, 0, 0, 8'h00};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 1, 0, 0, 8'hFF};
        vecs[6] = '{8'h3C, 1'b0, 1'b1, 0, 1, 0, 8'hFF};

        rst_n = 1'b0;
        uart_rxd = 1'b1;
        rx_if.rx_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_data", int'(rx_if.rx_data), 0);
        checkOutput("reset_valid", int'(rx_if.rx_valid), 0);
        checkOutput("reset_ferr", int'(rx_if.frame_err), 0);
        checkOutput("reset_ovr", int'(rx_if.overrun), 0);
        checkOutput("reset_busy", int'(rx_if.busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        line_idle(8);

        // First frame: exact busy and strobe latency from the pin falling edge.
        n0 = valid_cyc_q.size();
        send_frame(8'hA5, 1'b1, 1'b0, sc);
        line_idle(2 * CPB);
        checkOutput("lat_count", valid_cyc_q.size() - n0, 1);
        if (valid_cyc_q.size() > n0) begin
            checkOutput("lat_valid", valid_cyc_q[n0] - sc, LAT);
            checkOutput("lat_data", int'(valid_dat_q[n0]), 8'hA5);
        end
        checkOutput("lat_busy", busy_rise_cyc - sc, 3);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

        // Short low glitch: false start, no pulses, busy falls again.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        b0 = busy_rise_cnt;
        @(posedge clk);
        #1;
        uart_rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        uart_rxd = 1'b1;
        line_idle(2 * CPB);
        @(negedge clk);
        checkOutput("glitch_valid", valid_cnt - v0, 0);
        checkOutput("glitch_ferr", ferr_cnt - f0, 0);
        checkOutput("glitch_busy_rise", busy_rise_cnt - b0, 1);
        checkOutput("glitch_busy_now", int'(rx_if.busy), 0);

        // Back-to-back frames with no idle gap.
        n0 = valid_cyc_q.size();
        send_frame(8'h00, 1'b1, 1'b0, sc);
        send_frame(8'hFF, 1'b1, 1'b0, sc);
        line_idle(2 * CPB);
        checkOutput("b2b_count", valid_cyc_q.size() - n0, 2);
        if (valid_cyc_q.size() >= n0 + 2) begin
            checkOutput("b2b_gap", valid_cyc_q[n0 + 1] - valid_cyc_q[n0], FRAME_CYC);
            checkOutput("b2b_data0", int'(valid_dat_q[n0]), 8'h00);
            checkOutput("b2b_data1", int'(valid_dat_q[n0 + 1]), 8'hFF);
        end

        // Reset during bit 4 of 0xC3, then line held low after reset release.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        @(posedge clk);
        #1;
        uart_rxd = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_data", int'(rx_if.rx_data), 0);
        checkOutput("midrst_busy", int'(rx_if.busy), 0);
        checkOutput("midrst_valid", int'(rx_if.rx_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        b0 = busy_rise_cnt;
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        checkOutput("lowline_busy_rise", busy_rise_cnt - b0, 0);
        line_idle(2 * CPB);
        checkOutput("midrst_no_valid", valid_cnt - v0, 0);
        checkOutput("midrst_no_ferr", ferr_cnt - f0, 0);
        v0 = valid_cnt;
        send_frame(8'h7E, 1'b1, 1'b0, sc);
        line_idle(2 * CPB);
        checkOutput("after_rst_valid", valid_cnt - v0, 1);
        checkOutput("after_rst_data", int'(rx_if.rx_data), 8'h7E);

`ifdef UART_RX_PARITY_EN
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h81, 1'b1, 1'b1, sc);
        line_idle(2 * CPB);
        checkOutput("par_bad_ferr", ferr_cnt - f0, 1);
        checkOutput("par_bad_valid", valid_cnt - v0, 0);
        checkOutput("par_bad_data", int'(rx_if.rx_data), 8'h7E);
`endif

        checkOutput("no_wide_valid", wide_cnt, 0);
        checkOutput("no_ferr_ovr_same_cycle", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
